alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a single-cycle XOR/NAND/ADD path and a
// shift-add multiplier that takes WIDTH cycles (one bit of B per cycle).
// Handshake: in_valid/in_ready on input, out_valid/out_ready on output.
// Optional macro ALU_SEQ_FLAGS_EN adds a registered flag_zero output.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic               flag_zero
`endif
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] OP_XOR  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t         state_q, state_d;
  logic [RW-1:0]  result_q, result_d;
  logic [RW-1:0]  acc_q, acc_d;
  logic [RW-1:0]  mcand_q, mcand_d;   // A, shifted left once per multiply step
  logic [WIDTH-1:0] mplier_q, mplier_d; // B, shifted right; bit 0 is the current bit
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]  alu_res;
  logic [RW-1:0]  partial;

  // Single-cycle operations, zero-extended to the full result width
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = {{(WIDTH-1){1'b0}}, {1'b0, a} + {1'b0, b}};
      OP_NAND: alu_res = {{WIDTH{1'b0}}, ~(a & b)};
      OP_XOR:  alu_res = {{WIDTH{1'b0}}, a ^ b};
      default: alu_res = '0;
    endcase
  end

  // Accumulator value after adding in the current multiplier bit
  assign partial = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Next-state and datapath control; result only changes when a
  // transaction completes, so it shows the last result during MUL
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            state_d  = MUL;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
          end else begin
            state_d  = DONE;
            result_d = alu_res;
          end
        end
      end
      MUL: begin
        acc_d    = partial;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          result_d = partial;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic flag_q;

  // Zero flag tracks the result register; it only changes with result
  always_ff @(posedge clk) begin
    if (rst) flag_q <= 1'b1;
    else     flag_q <= (result_d == '0);
  end

  assign flag_zero = flag_q;
`endif

endmodule
